// File: rtl/pwm_decoder.sv
// Recovers duty and period from a sampled PWM line, measured between rising edges.
// Flags a line that stops toggling (stuck low or stuck high) with periodic timeout strobes.
module pwm_decoder #(
  parameter int BITS = 5
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            pwmIn,
  output logic [BITS-1:0] duty,
  output logic [BITS:0]   period,
  output logic            dutyValid,
  output logic            periodErr,
  output logic            lost
);

  localparam logic [BITS:0]   CNT_MAX  = '1;
  localparam logic [BITS:0]   NOMINAL  = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS-1:0] DUTY_MAX = '1;
  localparam logic [BITS:0]   CNT_ONE  = {{BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  state_t        state;
  logic          s1_p0;
  logic          s2_p1;
  logic          s_prev_p2;
  logic          rise;
  logic [BITS:0] period_cnt;
  logic [BITS:0] high_cnt;

  function automatic logic [BITS-1:0] sat_duty(input logic [BITS:0] cnt);
    return cnt[BITS] ? DUTY_MAX : cnt[BITS-1:0];
  endfunction

  assign rise = s2_p1 & ~s_prev_p2;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      s1_p0      <= 1'b0;
      s2_p1      <= 1'b0;
      s_prev_p2  <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty       <= '0;
      period     <= '0;
      dutyValid  <= 1'b0;
      periodErr  <= 1'b0;
      lost       <= 1'b0;
    end else begin
      // stage p0 -> p1 -> p2: two-flop synchronizer plus edge-detect history
      s1_p0     <= pwmIn;
      s2_p1     <= s1_p0;
      s_prev_p2 <= s2_p1;
      dutyValid <= 1'b0;

      if (rise) begin
        // A rise always wins over a coincident timeout; the first rise after
        // IDLE or STUCK only opens a measurement window.
        period_cnt <= CNT_ONE;
        high_cnt   <= CNT_ONE;
        state      <= MEASURE;
        lost       <= 1'b0;
        if (state == MEASURE) begin
          period    <= period_cnt;
          duty      <= sat_duty(high_cnt);
          periodErr <= (period_cnt != NOMINAL);
          dutyValid <= 1'b1;
        end
      end else if (period_cnt == CNT_MAX) begin
        // Timeout: report the static line level and keep re-reporting every MAX cycles.
        state      <= STUCK;
        period_cnt <= CNT_ONE;
        high_cnt   <= {{BITS{1'b0}}, s2_p1};
        duty       <= s2_p1 ? DUTY_MAX : '0;
        period     <= '0;
        periodErr  <= 1'b1;
        dutyValid  <= 1'b1;
        lost       <= 1'b1;
      end else begin
        period_cnt <= period_cnt + CNT_ONE;
        high_cnt   <= high_cnt + {{BITS{1'b0}}, s2_p1};
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table of steady waveforms plus timeout and reset sequences.
module tb_pwm_decoder;

  localparam int BITS = 5;

  logic            clk = 1'b0;
  logic            resetN;
  logic            pwmIn;
  logic [BITS-1:0] duty;
  logic [BITS:0]   period;
  logic            dutyValid;
  logic            periodErr;
  logic            lost;

  pwm_decoder #(.BITS(BITS)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .pwmIn     (pwmIn),
    .duty      (duty),
    .period    (period),
    .dutyValid (dutyValid),
    .periodErr (periodErr),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Strobe recorder, sampled on the falling edge
  int stb_cnt = 0;
  int stb_cyc = 0;
  int stb_duty = 0;
  int stb_period = 0;
  int stb_err = 0;
  int stb_lost = 0;
  bit prev_vld = 1'b0;

  always @(negedge clk) begin
    if (dutyValid) begin
      stb_cnt    = stb_cnt + 1;
      stb_cyc    = cyc;
      stb_duty   = int'(duty);
      stb_period = int'(period);
      stb_err    = int'(periodErr);
      stb_lost   = int'(lost);
      checks     = checks + 1;
      if (prev_vld) begin
        errors = errors + 1;
        $display("FAIL back_to_back_valid: dutyValid high two cycles in a row at cycle %0d, required single pulse", cyc);
      end
    end
    prev_vld = dutyValid;
  end

  typedef struct {
    string name;
    int    high;
    int    low;
    int    exp_duty;
    int    exp_period;
    int    exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int high, input int low);
    pwmIn = 1'b1;
    repeat (high) step();
    pwmIn = 1'b0;
    repeat (low) step();
  endtask

  task automatic wait_strobe(input string name, input int base, input int limit);
    int n;
    n = 0;
    while (stb_cnt == base && n < limit) begin
      step();
      n++;
    end
    check(name, int'(stb_cnt > base), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    int r;
    int base;

    vecs[0] = '{"b10",     10, 22, 10, 32, 0};
    vecs[1] = '{"b31",     31,  1, 31, 32, 0};
    vecs[2] = '{"b1",       1, 31,  1, 32, 0};
    vecs[3] = '{"h36_l4",  36,  4, 31, 40, 1};
    vecs[4] = '{"h20_l20", 20, 20, 20, 40, 1};

    // Reset state
    resetN = 1'b0;
    pwmIn  = 1'b0;
    repeat (3) step();
    check("rst_duty",      int'(duty), 0);
    check("rst_period",    int'(period), 0);
    check("rst_dutyValid", int'(dutyValid), 0);
    check("rst_periodErr", int'(periodErr), 0);
    check("rst_lost",      int'(lost), 0);

    // Stuck low from reset: counter hits 63 after edge 63, strobe registered at edge 64
    c0 = cyc;
    resetN = 1'b1;
    wait_strobe("stuck_low_seen", 0, 80);
    check("stuck_low_first_cycle", stb_cyc - c0, 64);
    check("stuck_low_duty",   stb_duty, 0);
    check("stuck_low_period", stb_period, 0);
    check("stuck_low_err",    stb_err, 1);
    check("stuck_low_lost",   stb_lost, 1);
    c1 = stb_cyc;
    wait_strobe("stuck_low_repeat_seen", 1, 80);
    check("stuck_low_repeat_gap", stb_cyc - c1, 63);
    check("stuck_low_count", stb_cnt, 2);

    // Brightness 10: first rise opens the window, second rise gives a strobe 3 clocks later
    base = stb_cnt;
    drive_period(10, 22);
    check("b10_first_rise_no_strobe", stb_cnt, base);
    check("b10_lost_cleared", int'(lost), 0);
    r = cyc;
    drive_period(10, 22);
    check("b10_strobe_count", stb_cnt, base + 1);
    check("b10_latency",      stb_cyc - r, 3);
    check("b10_duty",         stb_duty, 10);
    check("b10_period",       stb_period, 32);
    check("b10_err",          stb_err, 0);

    // Steady waveforms: warm up three periods, then observe two
    for (int i = 0; i < 5; i++) begin
      repeat (3) drive_period(vecs[i].high, vecs[i].low);
      base = stb_cnt;
      repeat (2) drive_period(vecs[i].high, vecs[i].low);
      check({vecs[i].name, "_count"},  stb_cnt - base, 2);
      check({vecs[i].name, "_duty"},   stb_duty, vecs[i].exp_duty);
      check({vecs[i].name, "_period"}, stb_period, vecs[i].exp_period);
      check({vecs[i].name, "_err"},    stb_err, vecs[i].exp_err);
      check({vecs[i].name, "_lost"},   int'(lost), 0);
    end

    // Locked at 10, then held high
    repeat (3) drive_period(10, 22);
    r = cyc;
    base = stb_cnt;
    pwmIn = 1'b1;
    wait_strobe("hold_rise_seen", base, 10);
    check("hold_rise_duty", stb_duty, 10);
    base = stb_cnt;
    wait_strobe("stuck_high_seen", base, 80);
    check("stuck_high_cycle",  stb_cyc - r, 66);
    check("stuck_high_duty",   stb_duty, 31);
    check("stuck_high_period", stb_period, 0);
    check("stuck_high_err",    stb_err, 1);
    check("stuck_high_lost",   stb_lost, 1);
    c1 = stb_cyc;
    base = stb_cnt;
    wait_strobe("stuck_high_repeat_seen", base, 80);
    check("stuck_high_repeat_gap",  stb_cyc - c1, 63);
    check("stuck_high_repeat_duty", stb_duty, 31);
    check("stuck_high_lost_level",  int'(lost), 1);
    pwmIn = 1'b0;
    repeat (22) step();
    base = stb_cnt;
    drive_period(10, 22);
    check("recover_no_strobe", stb_cnt, base);
    check("recover_lost",      int'(lost), 0);
    drive_period(10, 22);
    check("recover_count",  stb_cnt, base + 1);
    check("recover_duty",   stb_duty, 10);
    check("recover_period", stb_period, 32);
    check("recover_err",    stb_err, 0);

    // Asynchronous reset mid-period while locked
    repeat (2) drive_period(10, 22);
    pwmIn = 1'b1;
    repeat (5) step();
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_duty",      int'(duty), 0);
    check("async_rst_period",    int'(period), 0);
    check("async_rst_dutyValid", int'(dutyValid), 0);
    check("async_rst_periodErr", int'(periodErr), 0);
    check("async_rst_lost",      int'(lost), 0);
    pwmIn = 1'b0;
    repeat (3) step();
    resetN = 1'b1;
    base = stb_cnt;
    drive_period(10, 22);
    check("post_rst_first_rise_no_strobe", stb_cnt, base);
    drive_period(10, 22);
    check("post_rst_count",  stb_cnt, base + 1);
    check("post_rst_duty",   stb_duty, 10);
    check("post_rst_period", stb_period, 32);
    check("post_rst_err",    stb_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
